regfile_write_arbiter: RTL and testbench

//  Owns the single write port of the Registers block (WriteReg/WriteData/RegWriteEnable).

---
 rtl/regfile_write_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Owns the single write port of the Registers block. After reset it walks
//   every register and writes zero, then arbitrates between the writeback
//   stage (wb, priority) and a multi-cycle unit (aux). Aux is forced through
//   once it has waited STARVE_LIMIT cycles behind wb.
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   wb_valid/wb_addr/wb_data         writeback request
//   wb_ready                         wb accepted when wb_valid && wb_ready
//   aux_valid/aux_addr/aux_data      multi-cycle unit request
//   aux_ready                        aux accepted when aux_valid && aux_ready
//   RegWriteEnable/WriteReg/WriteData registered write port to Registers
//   clear_done                       sticky high once the clear has finished
module regfile_write_arbiter #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 5,
   parameter int NUM_REGS       = 32,
   parameter int CLEAR_ON_RESET = 1,
   parameter int ZERO_REG_RO    = 1,
   parameter int STARVE_LIMIT   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_ready,
   input  logic              aux_valid,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_data,
   output logic              aux_ready,
   output logic              RegWriteEnable,
   output logic [ADDR_W-1:0] WriteReg,
   output logic [DATA_W-1:0] WriteData,
   output logic              clear_done
);

   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
   // One count past the last register: the extra cycle lets clear_done rise
   // one edge after the final clear write rather than alongside it.
   localparam logic [ADDR_W:0] CLR_END = (ADDR_W + 1)'(NUM_REGS);
   localparam bit ZERO_RO = (ZERO_REG_RO != 0);

   typedef enum logic {StClear, StRun} arbStateT;

   localparam arbStateT RESET_STATE = (CLEAR_ON_RESET != 0) ? StClear : StRun;
   localparam logic     RESET_DONE  = (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;

   arbStateT              state;
   logic [ADDR_W:0]       clrCnt;
   logic [STARVE_W-1:0]   starveCnt;

   logic                  inRun;
   logic                  forceAux;
   logic                  wbAccept;
   logic                  auxAccept;
   logic [ADDR_W-1:0]     accAddr;
   logic [DATA_W-1:0]     accData;
   logic                  accWrites;

   always_comb begin
      // rst_n gates the readies so nothing is accepted while reset is held,
      // even when the reset state is RUN.
      inRun     = (state == StRun) && rst_n;
      forceAux  = aux_valid && (starveCnt == STARVE_MAX);
      wb_ready  = inRun && !forceAux;
      aux_ready = inRun && (forceAux || !wb_valid);
      wbAccept  = wb_valid && wb_ready;
      // aux_ready already excludes a simultaneous wb accept.
      auxAccept = aux_valid && aux_ready;
      accAddr   = wbAccept ? wb_addr : aux_addr;
      accData   = wbAccept ? wb_data : aux_data;
      accWrites = (wbAccept || auxAccept) && !(ZERO_RO && (accAddr == '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= RESET_STATE;
         clrCnt         <= '0;
         starveCnt      <= '0;
         RegWriteEnable <= 1'b0;
         WriteReg       <= '0;
         WriteData      <= '0;
         clear_done     <= RESET_DONE;
      end else begin
         case (state)
            StClear: begin
               starveCnt <= '0;
               if (clrCnt == CLR_END) begin
                  RegWriteEnable <= 1'b0;
                  clear_done     <= 1'b1;
                  clrCnt         <= '0;
                  state          <= StRun;
               end else begin
                  RegWriteEnable <= 1'b1;
                  WriteReg       <= clrCnt[ADDR_W-1:0];
                  WriteData      <= '0;
                  clrCnt         <= clrCnt + (ADDR_W + 1)'(1);
               end
            end
            StRun: begin
               RegWriteEnable <= accWrites;
               if (wbAccept || auxAccept) begin
                  WriteReg  <= accAddr;
                  WriteData <= accData;
               end
               if (!aux_valid || auxAccept)
                  starveCnt <= '0;
               else if (starveCnt != STARVE_MAX)
                  starveCnt <= starveCnt + STARVE_W'(1);
            end
            default: state <= StRun;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: the driver issues directed and random
// requests, predicts acceptance with its own arbitration model and queues the
// expected register writes; a monitor pops and compares each DUT write.
module tb_regfile_write_arbiter;

   localparam int DATA_W       = 32;
   localparam int ADDR_W       = 5;
   localparam int NUM_REGS     = 32;
   localparam int STARVE_LIMIT = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              wb_valid = 1'b0;
   logic [ADDR_W-1:0] wb_addr = '0;
   logic [DATA_W-1:0] wb_data = '0;
   logic              wb_ready;
   logic              aux_valid = 1'b0;
   logic [ADDR_W-1:0] aux_addr = '0;
   logic [DATA_W-1:0] aux_data = '0;
   logic              aux_ready;
   logic              RegWriteEnable;
   logic [ADDR_W-1:0] WriteReg;
   logic [DATA_W-1:0] WriteData;
   logic              clear_done;

   regfile_write_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
      .CLEAR_ON_RESET(1), .ZERO_REG_RO(1), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
      .aux_valid(aux_valid), .aux_addr(aux_addr), .aux_data(aux_data), .aux_ready(aux_ready),
      .RegWriteEnable(RegWriteEnable), .WriteReg(WriteReg), .WriteData(WriteData),
      .clear_done(clear_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wrT;

   wrT          expQ[$];
   int          checks = 0;
   int          errors = 0;
   int          edges = 0;
   int          starveM = 0;
   logic [DATA_W-1:0] dutRegs [NUM_REGS];
   logic [DATA_W-1:0] refRegs [NUM_REGS];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every write the DUT presents must match the oldest prediction.
   always @(negedge clk) begin : monitor
      wrT e;
      if (rst_n && RegWriteEnable === 1'b1) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got WriteReg=%0d WriteData=%0h, expected no write",
                     WriteReg, WriteData);
         end else begin
            e = expQ.pop_front();
            check("write_addr", 64'(WriteReg), 64'(e.addr));
            check("write_data", 64'(WriteData), 64'(e.data));
         end
         dutRegs[WriteReg] = WriteData;
      end
   end

   // One clock cycle of stimulus; entered and left at posedge+1.
   task automatic cycle(input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                        input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                        output logic wAcc, output logic aAcc);
      logic runM, forceM, expWr, expAr;
      wb_valid = wv; wb_addr = wa; wb_data = wd;
      aux_valid = av; aux_addr = aa; aux_data = ad;
      runM   = (edges >= NUM_REGS + 1);
      forceM = av && (starveM == STARVE_LIMIT);
      expWr  = runM && !forceM;
      expAr  = runM && (forceM || !wv);
      wAcc   = wv && expWr;
      aAcc   = av && expAr;
      if (wAcc && wa != '0) begin
         expQ.push_back('{addr: wa, data: wd});
         refRegs[wa] = wd;
      end else if (aAcc && aa != '0) begin
         expQ.push_back('{addr: aa, data: ad});
         refRegs[aa] = ad;
      end
      #3;
      check("wb_ready", 64'(wb_ready), 64'(expWr));
      check("aux_ready", 64'(aux_ready), 64'(expAr));
      check("clear_done", 64'(clear_done), 64'(runM));
      check("one_accept", 64'(wb_valid && wb_ready && aux_valid && aux_ready), 64'(0));
      if (!runM || !av || aAcc) starveM = 0;
      else if (starveM < STARVE_LIMIT) starveM = starveM + 1;
      @(posedge clk);
      edges++;
      #1;
   endtask

   task automatic idle(input int n);
      logic w, a;
      for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, w, a);
   endtask

   // Holds reset across an edge with a request asserted, checks the reset
   // values, releases at posedge+1 and queues the expected clear writes.
   task automatic applyReset();
      rst_n = 1'b0;
      wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h1111_2222;
      aux_valid = 1'b1; aux_addr = 5'd4; aux_data = 32'h3333_4444;
      expQ.delete();
      starveM = 0;
      @(posedge clk);
      #1;
      check("rst_we", 64'(RegWriteEnable), 64'(0));
      check("rst_waddr", 64'(WriteReg), 64'(0));
      check("rst_wdata", 64'(WriteData), 64'(0));
      check("rst_done", 64'(clear_done), 64'(0));
      check("rst_wb_ready", 64'(wb_ready), 64'(0));
      check("rst_aux_ready", 64'(aux_ready), 64'(0));
      wb_valid = 1'b0; aux_valid = 1'b0;
      rst_n = 1'b1;
      edges = 0;
      for (int i = 0; i < NUM_REGS; i++) begin
         expQ.push_back('{addr: ADDR_W'(i), data: '0});
         refRegs[i] = '0;
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic w, a, wbP, auxP;
      logic [ADDR_W-1:0] wa, aa;
      logic [DATA_W-1:0] wd, ad;
      int wbCnt;

      for (int i = 0; i < NUM_REGS; i++) begin
         dutRegs[i] = 32'hBAD0_BAD0;
         refRegs[i] = 32'hBAD0_BAD0;
      end
      #2;

      // Clear sequence interrupted at WriteReg=10, then restarted in full.
      applyReset();
      idle(11);
      check("t5_mid_clear_addr", 64'(WriteReg), 64'(10));
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_async_we", 64'(RegWriteEnable), 64'(0));
      check("t5_async_addr", 64'(WriteReg), 64'(0));
      check("t5_async_data", 64'(WriteData), 64'(0));
      applyReset();
      idle(NUM_REGS + 2);
      check("clear_drained", 64'(expQ.size()), 64'(0));

      // Single wb write, then the write port holds its last address.
      cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, w, a);
      idle(1);
      check("t2_hold_we", 64'(RegWriteEnable), 64'(0));
      check("t2_hold_addr", 64'(WriteReg), 64'(5));
      check("t2_hold_data", 64'(WriteData), 64'(32'hDEAD_BEEF));

      // wb and aux both held: aux forced through on the 4th cycle.
      wbCnt = 0; auxP = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 5'd3, 32'h100 + 32'(wbCnt), auxP, 5'd7, 32'hA5A5_A5A5, w, a);
         if (w) wbCnt++;
         if (a) auxP = 1'b0;
      end
      check("t3_wb_accepts", 64'(wbCnt), 64'(5));
      check("t3_aux_done", 64'(auxP), 64'(0));

      // Writes to register 0 complete the handshake without a write.
      cycle(1'b1, 5'd0, 32'h1234, 1'b0, '0, '0, w, a);
      cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'h5678, w, a);
      cycle(1'b0, '0, '0, 1'b1, 5'd12, 32'hCAFE_F00D, w, a);
      idle(2);

      // Random traffic with requesters holding until accepted.
      wbP = 1'b0; auxP = 1'b0;
      wa = '0; wd = '0; aa = '0; ad = '0;
      for (int i = 0; i < 200; i++) begin
         if (!wbP && $urandom_range(0, 99) < 60) begin
            wbP = 1'b1; wa = ADDR_W'($urandom_range(0, NUM_REGS - 1)); wd = $urandom;
         end
         if (!auxP && $urandom_range(0, 99) < 50) begin
            auxP = 1'b1; aa = ADDR_W'($urandom_range(0, NUM_REGS - 1)); ad = $urandom;
         end
         cycle(wbP, wa, wd, auxP, aa, ad, w, a);
         if (w) wbP = 1'b0;
         if (a) auxP = 1'b0;
      end
      idle(3);
      check("final_drained", 64'(expQ.size()), 64'(0));
      for (int i = 0; i < NUM_REGS; i++)
         check($sformatf("reg_readback[%0d]", i), 64'(dutRegs[i]), 64'(refRegs[i]));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
